// File: rtl/alu_pkg.sv
// Shared ALU opcode constants, FSM state encoding and default datapath width
// for the iterative multiply/divide unit.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1001;
  localparam logic [3:0] ALU_DIV = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift/accumulate registers with a shared adder/subtractor: one shift-add
// multiply bit or one restoring-division bit per step, on unsigned magnitudes.
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a_mag,
  input  logic [WIDTH-1:0] i_b_mag,
  output logic [WIDTH-1:0] o_lo_nxt,
  output logic [WIDTH-1:0] o_hi_nxt
);

  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_mq;
  logic [WIDTH-1:0] r_opd;

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_addsub;
  logic [WIDTH:0]   w_keep;
  logic [WIDTH:0]   w_acc_nxt;
  logic [WIDTH-1:0] w_mq_nxt;

  // Multiply: acc:mq holds the partial product, mq shifts the multiplier out.
  // Divide: acc holds the partial remainder, mq shifts dividend out and quotient in.
  always_comb begin
    w_shifted = {r_acc[WIDTH-1:0], r_mq[WIDTH-1]};
    w_addsub  = i_is_div ? (w_shifted - {1'b0, r_opd}) : (r_acc + {1'b0, r_opd});
    w_keep    = r_mq[0] ? w_addsub : r_acc;
    w_acc_nxt = {1'b0, w_keep[WIDTH:1]};
    w_mq_nxt  = {w_keep[0], r_mq[WIDTH-1:1]};
    if (i_is_div) begin
      if (w_addsub[WIDTH]) begin
        w_acc_nxt = w_shifted;
        w_mq_nxt  = {r_mq[WIDTH-2:0], 1'b0};
      end else begin
        w_acc_nxt = w_addsub;
        w_mq_nxt  = {r_mq[WIDTH-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_acc <= '0;
      r_mq  <= i_is_div ? i_a_mag : i_b_mag;
      r_opd <= i_is_div ? i_b_mag : i_a_mag;
    end else if (i_step) begin
      r_acc <= w_acc_nxt;
      r_mq  <= w_mq_nxt;
    end
  end

  assign o_lo_nxt = w_mq_nxt;
  assign o_hi_nxt = w_acc_nxt[WIDTH-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: IDLE/BUSY/DONE control, iteration counter and
// result registers. Define MULDIV_SIGNED_EN for two's-complement operation.
module mul_div_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       ALUop,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic             r_bzero;

  logic             w_accept;
  logic             w_is_div;
  logic             w_step;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_res_hi;
  logic             w_fin;
  logic [WIDTH-1:0] w_fin_lo;
  logic [WIDTH-1:0] w_fin_hi;

  assign w_accept = start && (r_state != ST_BUSY);
  assign w_is_div = w_accept ? (ALUop == ALU_DIV) : (r_op == ALU_DIV);
  assign w_step   = (r_state == ST_BUSY) &&
                    ((r_op == ALU_MUL) || ((r_op == ALU_DIV) && !r_bzero));

`ifdef MULDIV_SIGNED_EN
  logic r_sa;
  logic r_sb;

  assign w_a_mag = a_in[WIDTH-1] ? -a_in : a_in;
  assign w_b_mag = b_in[WIDTH-1] ? -b_in : b_in;

  // Sign fix-up applied to the final step's outputs as they are registered.
  always_comb begin
    w_res    = w_lo_nxt;
    w_res_hi = w_hi_nxt;
    if (r_op == ALU_MUL) begin
      if (r_sa ^ r_sb) {w_res_hi, w_res} = -{w_hi_nxt, w_lo_nxt};
    end else begin
      if (r_sa ^ r_sb) w_res = -w_lo_nxt;
      if (r_sa) w_res_hi = -w_hi_nxt;
    end
  end
`else
  assign w_a_mag  = a_in;
  assign w_b_mag  = b_in;
  assign w_res    = w_lo_nxt;
  assign w_res_hi = w_hi_nxt;
`endif

  always_comb begin
    w_fin    = 1'b0;
    w_fin_lo = w_res;
    w_fin_hi = w_res_hi;
    if ((r_op != ALU_MUL) && (r_op != ALU_DIV)) begin
      w_fin    = 1'b1;
      w_fin_lo = '0;
      w_fin_hi = '0;
    end else if ((r_op == ALU_DIV) && r_bzero) begin
      w_fin    = 1'b1;
      w_fin_lo = '1;
      w_fin_hi = r_a;
    end else if (r_cnt == CNT_W'(WIDTH - 1)) begin
      w_fin    = 1'b1;
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .i_load   (w_accept),
    .i_step   (w_step),
    .i_is_div (w_is_div),
    .i_a_mag  (w_a_mag),
    .i_b_mag  (w_b_mag),
    .o_lo_nxt (w_lo_nxt),
    .o_hi_nxt (w_hi_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_bzero   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b1;
`ifdef MULDIV_SIGNED_EN
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_state <= ST_BUSY;
            r_cnt   <= '0;
            r_op    <= ALUop;
            r_a     <= a_in;
            r_bzero <= (b_in == '0);
            busy    <= 1'b1;
`ifdef MULDIV_SIGNED_EN
            r_sa    <= a_in[WIDTH-1];
            r_sb    <= b_in[WIDTH-1];
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_fin) begin
            r_state   <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            result    <= w_fin_lo;
            result_hi <= w_fin_hi;
            zero      <= (w_fin_lo == '0);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_mul_div_unit;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [3:0]   ALUop;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .ALUop     (ALUop),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero)
  );

  // Reference model: what the unit should return and how long it should stay busy.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] lo, output logic [W-1:0] hi, output int nb);
    longint sa, sb, p, q, r;
`ifdef MULDIV_SIGNED_EN
    sa = longint'($signed(a));
    sb = longint'($signed(b));
`else
    sa = longint'({32'd0, a});
    sb = longint'({32'd0, b});
`endif
    nb = W;
    if (op == ALU_MUL) begin
      p  = sa * sb;
      lo = p[W-1:0];
      hi = p[2*W-1:W];
    end else if (op == ALU_DIV && b == '0) begin
      lo = '1;
      hi = a;
      nb = 1;
    end else if (op == ALU_DIV) begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q[W-1:0];
      hi = r[W-1:0];
    end else begin
      lo = '0;
      hi = '0;
      nb = 1;
    end
  endtask

  // Pulse start with one op, scramble inputs afterwards, then observe until done.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int nb, output bit got, output bit ovl,
                        output logic [W-1:0] lo, output logic [W-1:0] hi, output logic z);
    @(negedge clk);
    start = 1'b1; ALUop = op; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0; ALUop = 4'($urandom); a_in = $urandom; b_in = $urandom;
    nb = 0; got = 0; ovl = 0; lo = '0; hi = '0; z = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      if (busy && done) ovl = 1;
      if (done) begin
        got = 1; lo = result; hi = result_hi; z = zero;
        break;
      end
      if (busy) nb++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; ALUop = '0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || result_hi !== '0 || zero !== 1'b1) begin
      errs++;
      $display("FAIL reset_state: busy=%b done=%b result=%h hi=%h zero=%b, want 0 0 0 0 1",
               busy, done, result, result_hi, zero);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || zero !== 1'b1) begin
      errs++;
      $display("FAIL idle_after_reset: busy=%b done=%b zero=%b, want 0 0 1", busy, done, zero);
    end
  endtask

  task automatic test_mul();
    int nb; bit got, ovl; logic [W-1:0] lo, hi, elo, ehi; logic z; int enb;
    logic [W-1:0] av [3] = '{32'd10, 32'hFFFF_FFFF, 32'd0};
    logic [W-1:0] bv [3] = '{32'd6,  32'hFFFF_FFFF, 32'h1234_5678};
    for (int k = 0; k < 3; k++) begin
      run_op(ALU_MUL, av[k], bv[k], nb, got, ovl, lo, hi, z);
      model(ALU_MUL, av[k], bv[k], elo, ehi, enb);
      checks++;
      if (!got || nb != enb || lo !== elo || hi !== ehi || z !== (elo == '0)) begin
        errs++;
        $display("FAIL mul_%0d: got=%0d busy=%0d lo=%h hi=%h z=%b, want busy=%0d lo=%h hi=%h z=%b",
                 k, got, nb, lo, hi, z, enb, elo, ehi, (elo == '0));
      end
    end
    run_op(ALU_MUL, 32'd10, 32'd6, nb, got, ovl, lo, hi, z);
    checks++;
    if (!got || nb != 32 || lo !== 32'd60 || hi !== 32'd0 || z !== 1'b0) begin
      errs++;
      $display("FAIL mul_10x6: got=%0d busy=%0d lo=%0d hi=%0d z=%b, want 32 60 0 0", got, nb, lo, hi, z);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd60 || zero !== 1'b0) begin
      errs++;
      $display("FAIL result_hold: done=%b busy=%b result=%0d zero=%b, want 0 0 60 0", done, busy, result, zero);
    end
  endtask

  task automatic test_div();
    int nb; bit got, ovl; logic [W-1:0] lo, hi; logic z;
    run_op(ALU_DIV, 32'd10, 32'd5, nb, got, ovl, lo, hi, z);
    checks++;
    if (!got || nb != 32 || lo !== 32'd2 || hi !== 32'd0) begin
      errs++;
      $display("FAIL div_10_5: got=%0d busy=%0d q=%0d r=%0d, want 32 2 0", got, nb, lo, hi);
    end
    run_op(ALU_DIV, 32'd7, 32'd3, nb, got, ovl, lo, hi, z);
    checks++;
    if (!got || lo !== 32'd2 || hi !== 32'd1 || z !== 1'b0) begin
      errs++;
      $display("FAIL div_7_3: got=%0d q=%0d r=%0d z=%b, want 2 1 0", got, lo, hi, z);
    end
    run_op(ALU_DIV, 32'd3, 32'd7, nb, got, ovl, lo, hi, z);
    checks++;
    if (!got || lo !== 32'd0 || hi !== 32'd3 || z !== 1'b1) begin
      errs++;
      $display("FAIL div_3_7: got=%0d q=%0d r=%0d z=%b, want 0 3 1", got, lo, hi, z);
    end
  endtask

  task automatic test_div_zero();
    int nb; bit got, ovl; logic [W-1:0] lo, hi; logic z;
    run_op(ALU_DIV, 32'd7, 32'd0, nb, got, ovl, lo, hi, z);
    checks++;
    if (!got || nb != 1 || lo !== 32'hFFFF_FFFF || hi !== 32'd7 || z !== 1'b0) begin
      errs++;
      $display("FAIL div_zero: got=%0d busy=%0d q=%h r=%0d z=%b, want 1 ffffffff 7 0", got, nb, lo, hi, z);
    end
  endtask

  task automatic test_bad_op();
    int nb; bit got, ovl; logic [W-1:0] lo, hi; logic z;
    run_op(ALU_ADD, 32'd5, 32'd9, nb, got, ovl, lo, hi, z);
    checks++;
    if (!got || nb != 1 || lo !== '0 || hi !== '0 || z !== 1'b1) begin
      errs++;
      $display("FAIL bad_op: got=%0d busy=%0d lo=%h hi=%h z=%b, want 1 0 0 1", got, nb, lo, hi, z);
    end
  endtask

  task automatic test_reset_mid();
    int nb; bit got, ovl, seen; logic [W-1:0] lo, hi; logic z;
    @(negedge clk);
    start = 1'b1; ALUop = ALU_MUL; a_in = 32'd10; b_in = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || result_hi !== '0 || zero !== 1'b1) begin
      errs++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b result=%h hi=%h zero=%b, want 0 0 0 0 1",
               busy, done, result, result_hi, zero);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    checks++;
    if (seen) begin
      errs++;
      $display("FAIL reset_mid_no_done: activity seen=%0d, want 0", seen);
    end
    run_op(ALU_MUL, 32'd3, 32'd4, nb, got, ovl, lo, hi, z);
    checks++;
    if (!got || lo !== 32'd12 || hi !== '0) begin
      errs++;
      $display("FAIL mul_after_reset: got=%0d lo=%0d hi=%0d, want 12 0", got, lo, hi);
    end
  endtask

  task automatic test_back_to_back();
    int nb, n; bit got, ovl; logic [W-1:0] lo, hi; logic z;
    run_op(ALU_MUL, 32'd100, 32'd7, nb, got, ovl, lo, hi, z);
    checks++;
    if (!got || lo !== 32'd700) begin
      errs++;
      $display("FAIL b2b_first: got=%0d lo=%0d, want 700", got, lo);
    end
    // Still inside the DONE cycle: issue the second op immediately.
    start = 1'b1; ALUop = ALU_DIV; a_in = 32'd1000; b_in = 32'd7;
    n = 0; got = 0; nb = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == 5) begin
        start = 1'b1; ALUop = ALU_MUL; a_in = 32'd3; b_in = 32'd3;
      end
      if (done) begin got = 1; break; end
      if (busy) nb++;
    end
    start = 1'b0;
    checks++;
    if (!got || n != 33 || nb != 32 || result !== 32'd142 || result_hi !== 32'd6) begin
      errs++;
      $display("FAIL b2b_second: got=%0d spacing=%0d busy=%0d q=%0d r=%0d, want 33 32 142 6",
               got, n, nb, result, result_hi);
    end
  endtask

  task automatic test_random();
    int nb, enb; bit got, ovl; logic [W-1:0] lo, hi, elo, ehi, a, b; logic z; logic [3:0] op;
    for (int k = 0; k < 40; k++) begin
      case ($urandom % 8)
        0, 1, 2: op = ALU_MUL;
        3, 4, 5, 6: op = ALU_DIV;
        default: begin
          op = 4'($urandom);
          if (op == ALU_MUL || op == ALU_DIV) op = ALU_NOR;
        end
      endcase
      a = ($urandom % 2) ? $urandom : ($urandom % 256);
      b = ($urandom % 2) ? $urandom : ($urandom % 256);
      if ($urandom % 8 == 0) b = '0;
      run_op(op, a, b, nb, got, ovl, lo, hi, z);
      model(op, a, b, elo, ehi, enb);
      checks++;
      if (!got || ovl || nb != enb || lo !== elo || hi !== ehi || z !== (elo == '0)) begin
        errs++;
        $display("FAIL rand_%0d op=%b a=%h b=%h: got=%0d ovl=%0d busy=%0d lo=%h hi=%h z=%b, want busy=%0d lo=%h hi=%h",
                 k, op, a, b, got, ovl, nb, lo, hi, z, enb, elo, ehi);
      end
    end
  endtask

`ifdef MULDIV_SIGNED_EN
  task automatic test_signed();
    int nb; bit got, ovl; logic [W-1:0] lo, hi; logic z;
    run_op(ALU_DIV, -32'sd10, 32'd3, nb, got, ovl, lo, hi, z);
    checks++;
    if (!got || lo !== -32'sd3 || hi !== -32'sd1) begin
      errs++;
      $display("FAIL signed_div: got=%0d q=%h r=%h, want fffffffd ffffffff", got, lo, hi);
    end
    run_op(ALU_MUL, -32'sd10, 32'd3, nb, got, ovl, lo, hi, z);
    checks++;
    if (!got || {hi, lo} !== -64'sd30) begin
      errs++;
      $display("FAIL signed_mul: got=%0d p=%h, want ffffffffffffffe2", got, {hi, lo});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_bad_op();
    test_reset_mid();
    test_back_to_back();
`ifdef MULDIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
